// File: rtl/freelist_multi.sv
// Multi-port tag free list: a circular array with a write pointer and two read pointers,
// one speculative and one committed, so uncommitted allocations can be rolled back by a flush.
module freelist_multi #(
   parameter int TAG_W       = 6,
   parameter int DEPTH       = 32,
   parameter int INIT_COUNT  = 16,
   parameter int INIT_BASE   = 33,
   parameter int INIT_STRIDE = 2
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [1:0]               i_alloc_cnt,
   output logic [TAG_W-1:0]         o_tag0,
   output logic [TAG_W-1:0]         o_tag1,
   output logic                     o_alloc_ok,
   output logic [$clog2(DEPTH):0]   o_avail,
   input  logic [1:0]               i_free_vld,
   input  logic [TAG_W-1:0]         i_free_tag0,
   input  logic [TAG_W-1:0]         i_free_tag1,
   input  logic [1:0]               i_commit_cnt,
   input  logic                     i_flush,
   output logic                     o_err
);
   localparam int PW = $clog2(DEPTH) + 1;
   localparam int AW = PW - 1;

   logic [PW-1:0]    wr_q, wr_d, srd_q, srd_d, crd_q, crd_d;
   logic             err_q, err_d;
   logic [TAG_W-1:0] mem_q [DEPTH];

   logic [PW-1:0]    avail, occ, specd, free_cnt, alloc_ext, cmt_ext;
   logic             free_ok, cmt_ok, alloc_ok;
   logic [AW-1:0]    wa0, wa1, ra0, ra1;
   logic             we0, we1;
   logic [TAG_W-1:0] wd0;

   assign avail     = wr_q - srd_q;
   assign occ       = wr_q - crd_q;
   assign specd     = srd_q - crd_q;
   assign free_cnt  = PW'(i_free_vld[0]) + PW'(i_free_vld[1]);
   assign alloc_ext = PW'(i_alloc_cnt);
   assign cmt_ext   = PW'(i_commit_cnt);

   assign cmt_ok   = (cmt_ext <= specd);
   assign free_ok  = ((occ + free_cnt) <= PW'(DEPTH));
   // Allocation sees only pre-cycle availability; same-cycle frees are not bypassed.
   assign alloc_ok = (i_alloc_cnt != 2'd3) && (alloc_ext <= avail);

   always_comb begin
      wr_d  = wr_q;
      srd_d = srd_q;
      crd_d = crd_q;
      err_d = err_q;
      if (cmt_ok) crd_d = crd_q + cmt_ext;
      else        err_d = 1'b1;
      if (free_ok) wr_d = wr_q + free_cnt;
      else         err_d = 1'b1;
      if (i_flush)       srd_d = crd_d;
      else if (alloc_ok) srd_d = srd_q + alloc_ext;
      else               err_d = 1'b1;
   end

   // Frees are compacted: the first valid tag always lands at wr.
   assign wa0 = wr_q[AW-1:0];
   assign wa1 = wa0 + AW'(1);
   assign we0 = free_ok && (|i_free_vld);
   assign we1 = free_ok && (&i_free_vld);
   assign wd0 = i_free_vld[0] ? i_free_tag0 : i_free_tag1;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_q  <= PW'(INIT_COUNT);
         srd_q <= '0;
         crd_q <= '0;
         err_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         srd_q <= srd_d;
         crd_q <= crd_d;
         err_q <= err_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < INIT_COUNT; i++)
            mem_q[i] <= TAG_W'(INIT_BASE + i * INIT_STRIDE);
      end else begin
         if (we0) mem_q[wa0] <= wd0;
         if (we1) mem_q[wa1] <= i_free_tag1;
      end
   end

   assign ra0        = srd_q[AW-1:0];
   assign ra1        = ra0 + AW'(1);
   assign o_tag0     = mem_q[ra0];
   assign o_tag1     = mem_q[ra1];
   assign o_avail    = avail;
   assign o_alloc_ok = (avail >= PW'(2));
   assign o_err      = err_q;
endmodule

// File: tb/tb_freelist_multi.sv
// Bench for freelist_multi: directed vector table, hand sequences for error and boundary
// cases, and a queue-based reference model for random legal traffic.
module tb_freelist_multi;
   localparam int TAG_W = 6;
   localparam int DEPTH = 32;
   localparam int PW    = 6;

   logic             clk = 1'b0;
   logic             i_reset;
   logic [1:0]       i_alloc_cnt, i_free_vld, i_commit_cnt;
   logic [TAG_W-1:0] i_free_tag0, i_free_tag1;
   logic             i_flush;
   logic [TAG_W-1:0] o_tag0, o_tag1;
   logic             o_alloc_ok, o_err;
   logic [PW-1:0]    o_avail;

   always #5 clk = ~clk;

   freelist_multi #(.TAG_W(TAG_W), .DEPTH(DEPTH), .INIT_COUNT(16), .INIT_BASE(33), .INIT_STRIDE(2)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_alloc_cnt(i_alloc_cnt),
      .o_tag0(o_tag0), .o_tag1(o_tag1), .o_alloc_ok(o_alloc_ok), .o_avail(o_avail),
      .i_free_vld(i_free_vld), .i_free_tag0(i_free_tag0), .i_free_tag1(i_free_tag1),
      .i_commit_cnt(i_commit_cnt), .i_flush(i_flush), .o_err(o_err)
   );

   typedef struct {
      string nm;
      int    t0, t1, av, ok, err;
   } exp_t;

   typedef struct {
      int a, fv, f0, f1, c, fl, t0, t1, av, err;
   } vec_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // A negative expected tag means that output is not checked this cycle.
   function automatic exp_t mk(string nm, int t0, int t1, int av, int err);
      exp_t e;
      e.nm = nm; e.t0 = t0; e.t1 = t1; e.av = av; e.ok = (av >= 2) ? 1 : 0; e.err = err;
      return e;
   endfunction

   function automatic int min2(int v);
      return (v < 2) ? v : 2;
   endfunction

   task automatic drive(int a, int fv, int f0, int f1, int c, int fl);
      i_alloc_cnt  = 2'(a);
      i_free_vld   = 2'(fv);
      i_free_tag0  = TAG_W'(f0);
      i_free_tag1  = TAG_W'(f1);
      i_commit_cnt = 2'(c);
      i_flush      = fl[0];
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_chk++;
         $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
         e = sb_q.pop_front();
         if (e.t0 >= 0) chk({e.nm, ".tag0"}, int'(o_tag0), e.t0);
         if (e.t1 >= 0) chk({e.nm, ".tag1"}, int'(o_tag1), e.t1);
         chk({e.nm, ".avail"}, int'(o_avail), e.av);
         chk({e.nm, ".ok"}, int'(o_alloc_ok), e.ok);
         chk({e.nm, ".err"}, int'(o_err), e.err);
      end
   endtask

   task automatic cyc(string nm, int a, int fv, int f0, int f1, int c, int fl,
                      int t0, int t1, int av, int err);
      drive(a, fv, f0, f1, c, fl);
      sb_q.push_back(mk(nm, t0, t1, av, err));
      step();
   endtask

   // Reset is issued with busy inputs to show they are ignored and leave no residue.
   task automatic do_reset();
      i_reset = 1'b1;
      drive(2, 3, 1, 2, 1, 1);
      sb_q.push_back(mk("reset", 33, 35, 16, 0));
      step();
      i_reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
   endtask

   vec_t tbl[10];
   int   fl_q[$], sp_q[$], pool[$];

   initial begin
      tbl[0] = '{2, 0, 0,  0, 0, 0, 37, 39, 14, 0};
      tbl[1] = '{2, 0, 0,  0, 0, 0, 41, 43, 12, 0};
      tbl[2] = '{2, 0, 0,  0, 0, 0, 45, 47, 10, 0};
      tbl[3] = '{0, 0, 0,  0, 2, 0, 45, 47, 10, 0};
      tbl[4] = '{0, 0, 0,  0, 0, 1, 37, 39, 14, 0};
      tbl[5] = '{2, 0, 0,  0, 0, 0, 41, 43, 12, 0};
      tbl[6] = '{2, 0, 0,  0, 1, 1, 39, 41, 13, 0};
      tbl[7] = '{0, 2, 9,  5, 0, 0, 39, 41, 14, 0};
      tbl[8] = '{0, 3, 7,  8, 0, 0, 39, 41, 16, 0};
      tbl[9] = '{1, 1, 12, 0, 0, 0, 41, 43, 16, 0};

      i_reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].a, tbl[i].fv, tbl[i].f0, tbl[i].f1, tbl[i].c, tbl[i].fl);
         sb_q.push_back(mk($sformatf("vec%0d", i), tbl[i].t0, tbl[i].t1, tbl[i].av, tbl[i].err));
         step();
      end

      // Allocation larger than availability is refused, even with a same-cycle free.
      do_reset();
      for (int k = 1; k <= 7; k++)
         cyc($sformatf("fill%0d", k), 2, 0, 0, 0, 0, 0, 33 + 4 * k, 35 + 4 * k, 16 - 2 * k, 0);
      cyc("alloc1", 1, 0, 0, 0, 0, 0, 63, -1, 1, 0);
      cyc("over_alloc", 2, 0, 0, 0, 0, 0, 63, -1, 1, 1);
      cyc("no_bypass", 2, 1, 20, 0, 0, 0, 63, 20, 2, 1);

      // Free-side overflow near a full array.
      do_reset();
      for (int k = 1; k <= 7; k++)
         cyc($sformatf("free%0d", k), 0, 3, 2 * k, 2 * k + 1, 0, 0, 33, 35, 16 + 2 * k, 0);
      cyc("free_to31", 0, 1, 30, 0, 0, 0, 33, 35, 31, 0);
      cyc("free_drop", 0, 3, 31, 32, 0, 0, 33, 35, 31, 1);
      cyc("free_to32", 0, 1, 40, 0, 0, 0, 33, 35, 32, 1);

      do_reset();
      cyc("bad_commit", 0, 0, 0, 0, 1, 0, 33, 35, 16, 1);
      do_reset();
      cyc("alloc3", 3, 0, 0, 0, 0, 0, 33, 35, 16, 1);
      do_reset();
      cyc("flush_alloc3", 3, 0, 0, 0, 0, 1, 33, 35, 16, 0);

      // Port-1-only free is compacted to wr and read back once the head reaches it.
      do_reset();
      cyc("free_hi", 0, 2, 0, 5, 0, 0, 33, 35, 17, 0);
      for (int k = 1; k <= 8; k++)
         cyc($sformatf("walk%0d", k), 2, 0, 0, 0, 0, 0, (k < 8) ? 33 + 4 * k : 5,
             (k < 8) ? 35 + 4 * k : -1, 17 - 2 * k, 0);

      // Random legal traffic against a queue model of free, speculative and committed tags.
      do_reset();
      fl_q.delete(); sp_q.delete(); pool.delete();
      for (int i = 0; i < 16; i++) fl_q.push_back(33 + 2 * i);
      for (int n = 0; n < 80; n++) begin
         int a, c, nf, fl, fv, f0, f1, idx, hits;
         int frees[$];
         a  = $urandom_range(min2(fl_q.size()));
         c  = $urandom_range(min2(sp_q.size()));
         nf = $urandom_range(min2(pool.size()));
         fl = ($urandom_range(9) == 0) ? 1 : 0;
         frees.delete();
         for (int j = 0; j < nf; j++) begin
            idx = $urandom_range(pool.size() - 1);
            frees.push_back(pool[idx]);
            pool.delete(idx);
         end
         f0 = $urandom_range(63); f1 = $urandom_range(63);
         if (nf == 2) begin
            fv = 3; f0 = frees[0]; f1 = frees[1];
         end else if (nf == 1) begin
            fv = ($urandom_range(1) == 0) ? 1 : 2;
            if (fv == 1) f0 = frees[0]; else f1 = frees[0];
         end else begin
            fv = 0;
         end
         for (int j = 0; j < c; j++) pool.push_back(sp_q.pop_front());
         if (fl != 0) begin
            for (int j = sp_q.size() - 1; j >= 0; j--) fl_q.push_front(sp_q[j]);
            sp_q.delete();
         end else begin
            for (int j = 0; j < a; j++) begin
               int t;
               t = fl_q.pop_front();
               hits = 0;
               foreach (pool[q]) if (pool[q] == t) hits++;
               foreach (sp_q[q]) if (sp_q[q] == t) hits++;
               chk($sformatf("rnd%0d.uniq", n), hits, 0);
               sp_q.push_back(t);
            end
         end
         foreach (frees[j]) fl_q.push_back(frees[j]);
         drive(a, fv, f0, f1, c, fl);
         sb_q.push_back(mk($sformatf("rnd%0d", n), (fl_q.size() >= 1) ? fl_q[0] : -1,
                           (fl_q.size() >= 2) ? fl_q[1] : -1, fl_q.size(), 0));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/freelist_multi.md
FREELIST_MULTI -- requirements
Module: freelist_multi

Interface
REQ-001 SHALL have parameter TAG_W, default 6, meaning tag width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning entry count; must be a power of two and at least 4.
REQ-003 SHALL have parameter INIT_COUNT, default 16, meaning entries preloaded at reset; must be at most DEPTH.
REQ-004 SHALL have parameter INIT_BASE, default 33, meaning first preloaded tag.
REQ-005 SHALL have parameter INIT_STRIDE, default 2, meaning spacing between preloaded tags.
REQ-006 SHALL have port i_clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-007 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port i_alloc_cnt, input, 2 bits: tags requested this cycle (0..2; 3 treated as 0 and sets o_err).
REQ-009 SHALL have ports o_tag0 and o_tag1, output, TAG_W bits each: next two tags at the speculative head.
REQ-010 SHALL have port o_alloc_ok, input-independent output, 1 bit: high when avail >= 2.
REQ-011 SHALL have port o_avail, output, log2(DEPTH)+1 bits: unallocated entry count.
REQ-012 SHALL have ports i_free_vld, input, 2 bits, and i_free_tag0/i_free_tag1, input, TAG_W bits each: tags returned to the list.
REQ-013 SHALL have port i_commit_cnt, input, 2 bits: speculatively allocated tags made permanent (0..2).
REQ-014 SHALL have port i_flush, input, 1 bit: discard all uncommitted allocations.
REQ-015 SHALL have port o_err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-016 SHALL keep a DEPTH-entry circular array with three pointers of log2(DEPTH)+1 bits: wr, spec_rd and cmt_rd; all pointer arithmetic wraps modulo 2*DEPTH.
REQ-017 SHALL define avail = wr - spec_rd and occupied = wr - cmt_rd.
REQ-018 SHALL drive o_tag0 = mem[spec_rd] and o_tag1 = mem[spec_rd+1] combinationally (zero-latency read).
REQ-019 SHALL grant an allocation all-or-nothing: when i_alloc_cnt <= avail (pre-cycle value) and i_flush is low, spec_rd advances by i_alloc_cnt next cycle; otherwise spec_rd holds and o_err is set.
REQ-020 SHALL compact frees: the valid tags are written at wr, wr+1 in port order (tag0 first), and wr advances by popcount(i_free_vld).
REQ-021 SHALL accept frees only when occupied + popcount(i_free_vld) <= DEPTH; otherwise drop the whole free, hold wr, and set o_err.
REQ-022 SHALL advance cmt_rd by i_commit_cnt when i_commit_cnt <= spec_rd - cmt_rd; otherwise hold cmt_rd and set o_err.
REQ-023 SHALL, on i_flush, set spec_rd <= cmt_rd after any same-cycle commit advance and ignore i_alloc_cnt (no o_err); frees and commits in the same cycle are still applied.
REQ-024 SHALL compute availability for an allocation from pre-cycle state only, with no bypass of same-cycle frees.
REQ-025 SHALL apply alloc, free and commit in the same cycle independently when each is individually legal.

Reset
REQ-026 SHALL, while i_reset is high, set spec_rd = cmt_rd = 0, wr = INIT_COUNT, o_err = 0, and mem[i] = INIT_BASE + i*INIT_STRIDE (truncated to TAG_W) for i < INIT_COUNT; all other inputs are ignored.
REQ-027 SHALL, after reset, present o_avail = INIT_COUNT, o_tag0 = INIT_BASE, o_tag1 = INIT_BASE+INIT_STRIDE, and o_alloc_ok = (INIT_COUNT >= 2).
REQ-028 SHALL let reset asserted mid-operation discard all speculative, committed and freed state with no residue.

Verification
REQ-029 SHALL verify, with defaults: reset, then alloc 2 -> next cycle o_tag0=37, o_tag1=39, o_avail=14.
REQ-030 SHALL verify: alloc 2 three times, commit 2, then flush -> spec_rd returns to 2, o_tag0=37, o_avail=14.
REQ-031 SHALL verify: o_avail=1 and i_alloc_cnt=2 -> no pointer change, o_err=1, o_tag0 unchanged.
REQ-032 SHALL verify: occupied=31 and two frees -> both dropped, wr held, o_err=1; a single free at occupied=31 is accepted and occupied becomes 32.
REQ-033 SHALL verify: i_free_vld=2'b10 with tag 5 -> mem[wr]=5, wr+1, and the wrapped entry is later read back via o_tag0.
REQ-034 SHALL verify: 80 random legal alloc/free/commit cycles crossing the wrap point -> each tag is issued once per free and no o_err is raised.
